// File: rtl/result_pkg.sv
// result_pkg: shared round-state encoding, source IDs and default widths for result_collector.
package result_pkg;

    typedef enum logic [1:0] {IDLE, GOT1, GOT2, COMPLETE} round_state_t;

    localparam logic SRC_1 = 1'b0;
    localparam logic SRC_2 = 1'b1;

    localparam int DATA_W_DEF = 4;
    localparam int SUM_W_DEF  = 8;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: show-ahead synchronous FIFO with wrap-bit pointers; push while full is taken only alongside a pop.
module sync_fifo #(
    parameter int W     = 5,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wp, rp;
    logic         do_push, do_pop;

    assign empty    = wp == rp;
    assign full     = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rp[AW-1:0]];

    // storage is cleared too so the head reads zero straight out of reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wp[AW-1:0]] <= push_data;
                wp <= wp + (AW+1)'(1);
            end
            if (do_pop) rp <= rp + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/result_collector.sv
// result_collector: captures two slave result streams into holding registers, merges them round-robin
// into a tagged FIFO, and tracks per-round pair sums with a wrapping running total.
module result_collector
    import result_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 4,
    parameter int SUM_W  = SUM_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              done_1,
    input  logic [DATA_W-1:0] slave_out_1,
    input  logic              done_2,
    input  logic [DATA_W-1:0] slave_out_2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_src,
    output logic              round_done,
    output logic [DATA_W:0]   round_sum,
    output logic [SUM_W-1:0]  total_sum,
    output logic              overflow
);

    logic              h1_full, h2_full;
    logic [DATA_W-1:0] h1_data, h2_data;
    logic              rr;
    logic              cap1, cap2, grant1, grant2, push, pop, fifo_full, fifo_empty;
    logic [DATA_W:0]   push_data, head;

    round_state_t      state, state_n;
    logic [DATA_W-1:0] v1, v2, v1_n, v2_n;
    logic [DATA_W:0]   sum_n;

    assign cap1      = done_1 && !h1_full;
    assign cap2      = done_2 && !h2_full;
    assign pop       = out_valid && out_ready;
    assign grant1    = h1_full && (!h2_full || rr == SRC_1);
    assign grant2    = h2_full && !grant1;
    assign push      = (grant1 || grant2) && (!fifo_full || pop);
    assign push_data = grant1 ? {SRC_1, h1_data} : {SRC_2, h2_data};

    sync_fifo #(.W(DATA_W + 1), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = head[DATA_W-1:0];
    assign out_src   = head[DATA_W];

    // a holding register is only refilled once its flag has dropped, so a strobe in the push cycle is lost
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h1_full  <= 1'b0;
            h2_full  <= 1'b0;
            h1_data  <= '0;
            h2_data  <= '0;
            rr       <= SRC_1;
            overflow <= 1'b0;
        end else begin
            if (cap1) begin
                h1_full <= 1'b1;
                h1_data <= slave_out_1;
            end else if (push && grant1) h1_full <= 1'b0;
            if (cap2) begin
                h2_full <= 1'b1;
                h2_data <= slave_out_2;
            end else if (push && grant2) h2_full <= 1'b0;
            if (push) rr <= grant1 ? SRC_2 : SRC_1;
            if ((done_1 && h1_full) || (done_2 && h2_full)) overflow <= 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        v1_n    = v1;
        v2_n    = v2;
        if (state == GOT1) begin
            if (cap2) begin
                v2_n    = slave_out_2;
                state_n = COMPLETE;
            end
        end else if (state == GOT2) begin
            if (cap1) begin
                v1_n    = slave_out_1;
                state_n = COMPLETE;
            end
        end else begin
            if (cap1) v1_n = slave_out_1;
            if (cap2) v2_n = slave_out_2;
            state_n = (cap1 && cap2) ? COMPLETE : cap1 ? GOT1 : cap2 ? GOT2 : IDLE;
        end
    end

    assign sum_n = {1'b0, v1_n} + {1'b0, v2_n};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // sum and total load on entry to COMPLETE so they line up with the round_done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1         <= '0;
            v2         <= '0;
            round_done <= 1'b0;
            round_sum  <= '0;
            total_sum  <= '0;
        end else begin
            v1         <= v1_n;
            v2         <= v2_n;
            round_done <= state_n == COMPLETE;
            if (state_n == COMPLETE) begin
                round_sum <= sum_n;
                total_sum <= total_sum + SUM_W'(sum_n);
            end
        end
    end

endmodule

// File: tb/tb_result_collector.sv
// tb_result_collector: directed scenarios plus random traffic checked cycle by cycle against a queue-based model.
module tb_result_collector;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       done_1 = 1'b0, done_2 = 1'b0, out_ready = 1'b0;
    logic [3:0] slave_out_1 = '0, slave_out_2 = '0;
    logic       out_valid, out_src, round_done, overflow;
    logic [3:0] out_data;
    logic [4:0] round_sum;
    logic [7:0] total_sum;

    int unsigned errors = 0, checks = 0, pulses = 0, pops = 0;

    logic [4:0] q[$];
    bit         hf[2];
    logic [3:0] hd[2];
    int         ptr;
    bit         ovf, rd;
    bit         have[2];
    int         pv[2];
    int         rsum, total;

    result_collector #(.DATA_W(4), .DEPTH(DEPTH), .SUM_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .done_1      (done_1),
        .slave_out_1 (slave_out_1),
        .done_2      (done_2),
        .slave_out_2 (slave_out_2),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_src     (out_src),
        .round_done  (round_done),
        .round_sum   (round_sum),
        .total_sum   (total_sum),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        hf = '{0, 0};
        hd = '{0, 0};
        have = '{0, 0};
        pv = '{0, 0};
        ptr = 0;
        ovf = 0;
        rd = 0;
        rsum = 0;
        total = 0;
    endtask

    task automatic model_update(input bit d1, input logic [3:0] a, input bit d2, input logic [3:0] b, input bit rdy);
        bit         d[2], c[2], pop;
        logic [3:0] v[2];
        int         g;
        d[0] = d1; d[1] = d2; v[0] = a; v[1] = b;
        pop = rdy && q.size() > 0;
        g = (hf[0] && hf[1]) ? ptr : hf[0] ? 0 : hf[1] ? 1 : -1;
        for (int i = 0; i < 2; i++) begin
            c[i] = d[i] && !hf[i];
            if (d[i] && hf[i]) ovf = 1;
        end
        if (pop) void'(q.pop_front());
        if (g >= 0 && q.size() < DEPTH) begin
            q.push_back({g[0], hd[g]});
            hf[g] = 0;
            ptr = 1 - g;
        end
        for (int i = 0; i < 2; i++) if (c[i]) begin hf[i] = 1; hd[i] = v[i]; end
        rd = 0;
        for (int i = 0; i < 2; i++) if (c[i] && !have[i]) begin have[i] = 1; pv[i] = v[i]; end
        if (have[0] && have[1]) begin
            rd = 1;
            rsum = pv[0] + pv[1];
            total = (total + rsum) % 256;
            have = '{0, 0};
        end
    endtask

    task automatic step(input bit d1, input logic [3:0] a, input bit d2, input logic [3:0] b, input bit rdy);
        done_1 = d1; slave_out_1 = a; done_2 = d2; slave_out_2 = b; out_ready = rdy;
        @(negedge clk);
        check("valid", out_valid, q.size() > 0);
        if (q.size() > 0) begin
            check("data", out_data, q[0][3:0]);
            check("src", out_src, q[0][4]);
        end
        check("round_done", round_done, rd);
        check("round_sum", round_sum, rsum);
        check("total_sum", total_sum, total);
        check("overflow", overflow, ovf);
        if (round_done) pulses++;
        if (out_valid && out_ready) pops++;
        @(posedge clk);
        model_update(d1, a, d2, b, rdy);
        #1;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, rdy);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_data"}, out_data, 0);
        check({tag, "_src"}, out_src, 0);
        check({tag, "_rdone"}, round_done, 0);
        check({tag, "_rsum"}, round_sum, 0);
        check({tag, "_total"}, total_sum, 0);
        check({tag, "_ovf"}, overflow, 0);
    endtask

    task automatic do_reset();
        done_1 = 0; done_2 = 0;
        rst = 1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_zero("reset");
        rst = 0;
        model_reset();
        pulses = 0;
        pops = 0;
    endtask

    initial begin
        model_reset();
        do_reset();

        step(1, 4'h3, 0, 0, 1);
        idle(2, 1);
        step(0, 0, 1, 4'h5, 1);
        idle(4, 1);
        check("single_pulses", pulses, 1);
        check("single_sum", round_sum, 8);
        check("single_total", total_sum, 8);
        check("single_pops", pops, 2);

        step(1, 4'hF, 1, 4'hF, 1);
        idle(3, 1);
        check("simul_sum", round_sum, 30);
        step(1, 4'hA, 1, 4'hB, 1);
        idle(4, 1);
        check("simul_sum2", round_sum, 21);

        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1, 4'(2 * i + 1), 1, 4'(2 * i + 2), 0);
            idle(2, 0);
        end
        step(1, 4'h9, 0, 0, 0);
        idle(1, 0);
        check("bp_overflow", overflow, 1);
        check("bp_total", total_sum, 21);
        pops = 0;
        idle(10, 1);
        check("bp_drain", pops, 6);

        do_reset();
        for (int i = 0; i < 9; i++) begin
            step(1, 4'hF, 1, 4'hF, 1);
            idle(2, 1);
        end
        check("wrap_total", total_sum, 14);
        check("wrap_pulses", pulses, 9);

        do_reset();
        step(1, 4'h2, 0, 0, 1);
        idle(2, 1);
        step(1, 4'h7, 0, 0, 1);
        idle(2, 1);
        step(0, 0, 1, 4'h4, 1);
        idle(4, 1);
        check("dup_sum", round_sum, 6);
        check("dup_overflow", overflow, 0);
        check("dup_pops", pops, 3);

        do_reset();
        step(1, 4'h1, 0, 0, 0);
        idle(2, 0);
        step(0, 0, 1, 4'h2, 0);
        idle(1, 0);
        step(1, 4'h3, 0, 0, 0);
        idle(2, 0);
        check("mid_queued", q.size(), 3);
        #2 rst = 1;
        #1 check_zero("async");
        model_reset();
        @(posedge clk);
        #1 rst = 0;
        pulses = 0;
        step(0, 0, 1, 4'h9, 1);
        idle(4, 1);
        check("got2_no_pulse", pulses, 0);
        step(1, 4'h5, 0, 0, 1);
        idle(2, 1);
        check("got2_sum", round_sum, 14);

        for (int i = 0; i < 500; i++)
            step($urandom_range(2) == 0, 4'($urandom_range(15)), $urandom_range(2) == 0,
                 4'($urandom_range(15)), $urandom_range(4) < 3);
        idle(8, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/result_collector.md
Name: result_collector

Overview:
- Sits directly downstream of the two worker slaves driven by the controller.
- Captures each slave's 4-bit result on its done strobe and merges both streams into one FIFO-buffered valid/ready output tagged with the source ID.
- Tracks "rounds": a round is one result from each slave. Per completed round it publishes the pair sum and a wrapping running total, which the controller or a downstream stage consumes.

Parameters:
- DATA_W, 4, width of each slave result.
- DEPTH, 4, output FIFO entries; power of two, at least 2.
- SUM_W, 8, width of the running total; wraps modulo 2^SUM_W.

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- done_1  in  1  one-cycle strobe; slave 1 result valid this cycle.
- slave_out_1  in  DATA_W  slave 1 result.
- done_2  in  1  one-cycle strobe; slave 2 result valid this cycle.
- slave_out_2  in  DATA_W  slave 2 result.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  downstream accepts the head when out_valid && out_ready.
- out_data  out  DATA_W  FIFO head data.
- out_src  out  1  FIFO head source: 0 = slave 1, 1 = slave 2.
- round_done  out  1  one-cycle pulse when a round completes.
- round_sum  out  DATA_W+1  slave 1 value + slave 2 value for the last round.
- total_sum  out  SUM_W  wrapping accumulation of all round_sum values.
- overflow  out  1  sticky; a result was dropped.

Behaviour:
- Reset, asynchronous, active-high, legal at any time including mid-round:
  - All outputs go to 0.
  - FIFO is empty, holding registers are empty, round FSM is in IDLE, overflow is cleared.
  - Nothing survives reset.
- Capture:
  - Each channel has a 1-entry holding register (data + full flag).
  - done_n with its holding register empty: capture slave_out_n and set full.
  - done_n with its holding register full: drop the new value and set overflow (sticky until rst).
- Arbiter:
  - Moves at most one holding register per cycle into the FIFO.
  - Round-robin between channels; the pointer starts at slave 1 after reset and advances past the channel just granted.
  - Only one channel full: that channel is granted.
  - Push is allowed when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
  - A register captured at edge N is eligible to push at edge N+1. An entry therefore appears on out_valid no earlier than 2 cycles after its done strobe.
- FIFO:
  - Show-ahead: out_data/out_src always reflect the head entry; out_valid = not empty.
  - Pop when out_valid && out_ready.
  - Simultaneous push and pop: occupancy unchanged.
  - Pop with the FIFO empty has no effect.
  - Pointers are log2(DEPTH) bits plus a wrap bit.
  - If the FIFO is full, holding registers stall; the drop/overflow rule above then applies.
- Round FSM, driven at capture time (done strobes), independent of FIFO stalls; dropped values do not count. Operands are the captured values.
  - IDLE: done_1 only -> GOT1 (latch v1). done_2 only -> GOT2 (latch v2). Both -> COMPLETE (latch both).
  - GOT1: done_2 -> COMPLETE. A further done_1 is ignored for round purposes; the first value is kept.
  - GOT2: symmetric to GOT1.
  - COMPLETE, one cycle:
    - round_done = 1.
    - round_sum <= v1 + v2, zero-extended to DATA_W+1 bits.
    - total_sum <= total_sum + round_sum, truncated to SUM_W (wraps).
    - Transitions: no done -> IDLE; done_1 and/or done_2 in this cycle start the next round (-> GOT1, GOT2 or COMPLETE).
  - round_done is high exactly 1 cycle per round; round_sum and total_sum hold between rounds.
- All outputs are registered, except that out_valid/out_data/out_src are a direct read of FIFO registers.

Decomposition:
- Shared package result_pkg:
  - Round FSM state encoding: IDLE, GOT1, GOT2, COMPLETE.
  - Source ID constants SRC_1 = 0, SRC_2 = 1.
  - Default DATA_W and SUM_W.
- One sub-module, sync_fifo: parameterised width (DATA_W+1) and DEPTH; push/pop, full/empty; show-ahead read.
- Capture, arbiter and round FSM stay in result_collector.

Test Plan:
- Reset then single round: done_1 with 4'h3, 3 cycles later done_2 with 4'h5, out_ready=1.
  - round_done pulses once; round_sum=8; total_sum=8.
  - Output sequence is (src0, 3) then (src1, 5), each 2 cycles after its strobe.
- Simultaneous strobes: done_1=done_2=1 with 4'hF and 4'hF.
  - round_sum=30 (5-bit result, no truncation).
  - FIFO order is src0 then src1 (round-robin starts at slave 1).
  - The next simultaneous pair, A and B, emits src0 A first, since the pointer returned to slave 1 after granting slave 2.
- Backpressure/full: out_ready=0, 4 rounds of pairs 1..8 (DEPTH=4).
  - FIFO fills to 4 and both holding registers become full; the next done_1 sets overflow=1 and its value is absent.
  - With out_ready=1, the remaining entries drain in order with no duplicates.
- Wrap: SUM_W=8, 9 rounds of (15,15).
  - total_sum reads 30, 60, ..., 240, then 14 (270 mod 256).
- Out-of-order/duplicate: done_1(2), done_1(7), done_2(4).
  - round_sum=6 (the first slave 1 value is kept).
  - FIFO still carries 2, 7, 4, with overflow=0 if drained.
- Reset mid-operation: assert rst while in GOT1 with 3 entries queued.
  - All outputs are 0 immediately, before the next clock edge.
  - After release, done_2(9) alone leaves round_done low (FSM in GOT2).
